// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - handshake bundle between stream_demux and its environment
// Purpose: groups the single input stream, the N per-channel output streams and the
//   drop counter so stream_demux can take them as one interface port.
// Signals:
//   in_valid/in_data/in_sel/in_ready  - input beat, payload, destination channel, accept
//   out_valid[N]/out_data[N*W]        - per-channel held beat; channel k on [k*W +: W]
//   out_ready[N]                      - per-channel downstream accept
//   drop_cnt[16]                      - saturating count of beats sent to a missing channel
//   in_bcast                          - only with STREAM_DEMUX_BROADCAST_EN: load all channels
// Modports: master = environment (source and sinks), slave = the demux.
`timescale 1ns/1ps
interface stream_demux_if #(
  parameter int N = 16,
  parameter int W = 8
);
  localparam int SEL_W = $clog2(N);

  logic             in_valid;
  logic [W-1:0]     in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_ready;
  logic [N-1:0]     out_valid;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_ready;
  logic [15:0]      drop_cnt;

`ifdef STREAM_DEMUX_BROADCAST_EN
  logic             in_bcast;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, drop_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, drop_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, drop_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, drop_cnt
  );
`endif
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - one-input, N-output stream demultiplexer with one-entry channel registers
// Purpose: routes each accepted input beat to channel in_sel, where it is held in a
//   one-entry register until that channel's consumer takes it. Beats addressed to a
//   channel index >= N are accepted and discarded, counted in a saturating drop_cnt.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; empties every channel, clears data and drop_cnt
//   bus  - stream_demux_if.slave (in_*, out_*, drop_cnt, and in_bcast when enabled)
// Parameters: N output channels (2..64), W data bits (1..64).
// Optional feature: define STREAM_DEMUX_BROADCAST_EN to add in_bcast, which loads the
//   beat into every channel once all of them can take it.
`timescale 1ns/1ps
module stream_demux #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  stream_demux_if.slave bus
);
  localparam int SEL_W = $clog2(N);
  // N always fits in SEL_W+1 bits, so the range check needs no 32-bit compare.
  localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

  logic [N-1:0]   valid_q;
  logic [N*W-1:0] data_q;
  logic [15:0]    drop_q;

  logic [N-1:0]   slot_free;
  logic [N-1:0]   hit;
  logic [N-1:0]   load;
  logic           in_range;
  logic           sel_ready;
  logic           ready_int;
  logic           xfer;
  logic           drop;

  always_comb begin
    // A slot can take a new beat if it is empty or is being drained this cycle.
    slot_free = ~valid_q | bus.out_ready;
    in_range  = {1'b0, bus.in_sel} < N_EXT;
    hit       = '0;
    sel_ready = 1'b1;
    // Decode in_sel one-hot rather than indexing, so an out-of-range select
    // never reads past the channel vector and simply leaves sel_ready high.
    for (int k = 0; k < N; k++) begin
      if (in_range && (bus.in_sel == SEL_W'(k))) begin
        hit[k]    = 1'b1;
        sel_ready = slot_free[k];
      end
    end

`ifdef STREAM_DEMUX_BROADCAST_EN
    ready_int = bus.in_bcast ? (&slot_free) : sel_ready;
    xfer      = bus.in_valid && ready_int;
    load      = xfer ? (bus.in_bcast ? {N{1'b1}} : hit) : '0;
    drop      = xfer && !bus.in_bcast && !in_range;
`else
    ready_int = sel_ready;
    xfer      = bus.in_valid && ready_int;
    load      = xfer ? hit : '0;
    drop      = xfer && !in_range;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        // A reload wins over a drain so a back-to-back stream has no bubble.
        if (load[k]) begin
          valid_q[k]          <= 1'b1;
          data_q[k*W +: W]    <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          valid_q[k]          <= 1'b0;
        end
      end
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux (N=16 and N=10 instances)
`timescale 1ns/1ps
module tb_stream_demux;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_if #(.N(16), .W(W)) if16 ();
  stream_demux_if #(.N(10), .W(W)) if10 ();

  stream_demux #(.N(16), .W(W)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  stream_demux #(.N(10), .W(W)) dut10 (.clk(clk), .rst(rst), .bus(if10));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    if16.in_valid = 1'b0; if16.in_sel = '0; if16.in_data = '0; if16.out_ready = '0;
    if10.in_valid = 1'b0; if10.in_sel = '0; if10.in_data = '0; if10.out_ready = '0;
`ifdef STREAM_DEMUX_BROADCAST_EN
    if16.in_bcast = 1'b0;
    if10.in_bcast = 1'b0;
`endif
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference model: each channel is a FIFO of capacity one; index d*16+k.
  logic [7:0]  mq [32][$];
  logic [7:0]  mlast [32];
  int unsigned mdrop [2];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mq[i].delete();
      mlast[i] = 8'h00;
    end
    mdrop[0] = 0;
    mdrop[1] = 0;
  endtask

  task automatic model_cycle(input int d, input int n, input logic vld, input logic [3:0] sel,
                             input logic [7:0] data, input logic [15:0] ordy,
                             input logic act_rdy, input logic [15:0] act_ov,
                             input logic [127:0] act_od, input logic [15:0] act_drop);
    int b;
    logic rdy;
    logic [15:0] e_ov;
    logic [127:0] e_od;
    b = d * 16;
    rdy = (int'(sel) >= n) || (mq[b + int'(sel)].size() == 0) || ordy[sel];
    e_ov = '0;
    e_od = '0;
    for (int k = 0; k < n; k++) begin
      e_ov[k] = (mq[b + k].size() != 0);
      e_od[k*8 +: 8] = mlast[b + k];
    end
    chk($sformatf("rnd%0d_in_ready", d), act_rdy, rdy);
    chk($sformatf("rnd%0d_out_valid", d), act_ov, e_ov);
    chk($sformatf("rnd%0d_out_data", d), act_od, e_od);
    chk($sformatf("rnd%0d_drop_cnt", d), act_drop, 16'(mdrop[d]));
    for (int k = 0; k < n; k++)
      if (mq[b + k].size() != 0 && ordy[k]) void'(mq[b + k].pop_front());
    if (vld && rdy) begin
      if (int'(sel) >= n) begin
        if (mdrop[d] < 65535) mdrop[d]++;
      end else begin
        mq[b + int'(sel)].push_back(data);
        mlast[b + int'(sel)] = data;
      end
    end
  endtask

  typedef struct {
    logic        vld;
    logic [3:0]  sel;
    logic [7:0]  data;
    logic [15:0] ordy;
    logic        exp_rdy;
    logic [15:0] exp_ov;
    logic [3:0]  ch;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int acc;
    tbl[0]  = '{1'b1, 4'd5, 8'hA5, 16'h0000, 1'b1, 16'h0020, 4'd5, 8'hA5};
    tbl[1]  = '{1'b0, 4'd5, 8'h00, 16'h0000, 1'b0, 16'h0020, 4'd5, 8'hA5};
    tbl[2]  = '{1'b0, 4'd5, 8'h00, 16'h0020, 1'b1, 16'h0000, 4'd5, 8'hA5};
    tbl[3]  = '{1'b1, 4'd3, 8'h11, 16'h0000, 1'b1, 16'h0008, 4'd3, 8'h11};
    tbl[4]  = '{1'b1, 4'd3, 8'h3C, 16'h0008, 1'b1, 16'h0008, 4'd3, 8'h3C};
    tbl[5]  = '{1'b1, 4'd7, 8'h77, 16'h0008, 1'b1, 16'h0080, 4'd7, 8'h77};
    tbl[6]  = '{1'b1, 4'd7, 8'h78, 16'h0000, 1'b0, 16'h0080, 4'd7, 8'h77};
    tbl[7]  = '{1'b1, 4'd2, 8'h22, 16'h0000, 1'b1, 16'h0084, 4'd2, 8'h22};
    tbl[8]  = '{1'b1, 4'd7, 8'h78, 16'h0080, 1'b1, 16'h0084, 4'd7, 8'h78};
    tbl[9]  = '{1'b0, 4'd0, 8'h00, 16'hFFFF, 1'b1, 16'h0000, 4'd7, 8'h78};
    tbl[10] = '{1'b0, 4'd9, 8'hFF, 16'h0000, 1'b1, 16'h0000, 4'd9, 8'h00};

    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if16.in_sel = 4'd3;
    #1;
    chk("rst_out_valid16", if16.out_valid, 16'h0000);
    chk("rst_out_data16", if16.out_data, 128'h0);
    chk("rst_drop_cnt10", if10.drop_cnt, 16'h0000);
    chk("rst_in_ready16", if16.in_ready, 1'b1);
    chk("rst_in_ready10", if10.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: each vector is held for one cycle; in_ready checked mid-cycle,
    // registered outputs checked just after the following edge.
    for (int i = 0; i < 11; i++) begin
      if16.in_valid = tbl[i].vld;
      if16.in_sel = tbl[i].sel;
      if16.in_data = tbl[i].data;
      if16.out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), if16.in_ready, tbl[i].exp_rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid", i), if16.out_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_data", i), if16.out_data[int'(tbl[i].ch)*8 +: 8], tbl[i].exp_d);
    end

    // Ten back-to-back beats to channel 3 with the consumer always ready.
    acc = 0;
    for (int i = 0; i < 11; i++) begin
      if16.in_valid = (i < 10);
      if16.in_sel = 4'd3;
      if16.in_data = 8'(32'h40 + i);
      if16.out_ready = 16'h0008;
      @(negedge clk);
      if (if16.in_valid && if16.in_ready) acc++;
      if (i > 0) begin
        chk($sformatf("burst%0d_valid", i), if16.out_valid[3], 1'b1);
        chk($sformatf("burst%0d_data", i), if16.out_data[31:24], 8'(32'h40 + i - 1));
      end
      @(posedge clk); #1;
    end
    chk("burst_accepts", acc, 10);
    idle_all();
    chk("burst_drained", if16.out_valid, 16'h0000);

    // Asynchronous reset pulse between edges while channels 0 and 9 hold beats.
    if16.in_valid = 1'b1; if16.in_sel = 4'd0; if16.in_data = 8'hC0;
    if10.in_valid = 1'b1; if10.in_sel = 4'd0; if10.in_data = 8'hC0;
    @(posedge clk); #1;
    if16.in_sel = 4'd9; if16.in_data = 8'hC9;
    if10.in_sel = 4'd9; if10.in_data = 8'hC9;
    @(posedge clk); #1;
    if10.in_sel = 4'd12;
    if16.in_valid = 1'b0;
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    chk("pre_rst_valid16", if16.out_valid, 16'h0201);
    chk("pre_rst_valid10", if10.out_valid, 10'h201);
    chk("pre_rst_drop10", if10.drop_cnt, 16'd1);
    rst = 1'b1;
    #0.5;
    chk("async_rst_valid16", if16.out_valid, 16'h0000);
    chk("async_rst_data16", if16.out_data, 128'h0);
    chk("async_rst_valid10", if10.out_valid, 10'h000);
    chk("async_rst_data10", if10.out_data, 80'h0);
    chk("async_rst_drop10", if10.drop_cnt, 16'h0000);
    chk("async_rst_in_ready16", if16.in_ready, 1'b1);
    #0.5;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid16", if16.out_valid, 16'h0000);

    // Randomized traffic on both instances against the FIFO model.
    model_clear();
    for (int c = 0; c < 600; c++) begin
      if16.in_valid = ($urandom_range(0, 3) != 0);
      if16.in_sel = 4'($urandom_range(0, 15));
      if16.in_data = 8'($urandom);
      if16.out_ready = 16'($urandom);
      if10.in_valid = ($urandom_range(0, 3) != 0);
      if10.in_sel = 4'($urandom_range(0, 15));
      if10.in_data = 8'($urandom);
      if10.out_ready = 10'($urandom);
      @(negedge clk);
      model_cycle(0, 16, if16.in_valid, if16.in_sel, if16.in_data, if16.out_ready,
                  if16.in_ready, if16.out_valid, if16.out_data, if16.drop_cnt);
      model_cycle(1, 10, if10.in_valid, if10.in_sel, if10.in_data, {6'b0, if10.out_ready},
                  if10.in_ready, {6'b0, if10.out_valid}, {48'h0, if10.out_data}, if10.drop_cnt);
      @(posedge clk); #1;
    end

    // Drop counting and saturation on the N=10 instance.
    idle_all();
    sync_reset();
    if10.in_valid = 1'b1;
    if10.in_sel = 4'd12;
    if10.in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("drop%0d_in_ready", i), if10.in_ready, 1'b1);
      @(posedge clk); #1;
    end
    chk("drop3_cnt", if10.drop_cnt, 16'd3);
    chk("drop3_valid", if10.out_valid, 10'h000);
    if10.in_sel = 4'd10;
    @(posedge clk); #1;
    chk("drop_sel10_cnt", if10.drop_cnt, 16'd4);
    chk("drop_sel10_valid", if10.out_valid, 10'h000);
    if10.in_sel = 4'd9;
    if10.in_data = 8'h99;
    @(posedge clk); #1;
    chk("sel9_cnt", if10.drop_cnt, 16'd4);
    chk("sel9_valid", if10.out_valid, 10'h200);
    chk("sel9_data", if10.out_data[79:72], 8'h99);
    if10.in_sel = 4'd15;
    repeat (65537) @(posedge clk);
    #1;
    chk("drop_saturated", if10.drop_cnt, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_stays_saturated", if10.drop_cnt, 16'hFFFF);
    chk("drop_sat_ch9_held", if10.out_valid, 10'h200);

`ifdef STREAM_DEMUX_BROADCAST_EN
    idle_all();
    sync_reset();
    if16.in_valid = 1'b1; if16.in_bcast = 1'b1; if16.in_data = 8'h5A; if16.in_sel = 4'd1;
    @(negedge clk);
    chk("bc_empty_ready", if16.in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bc_all_valid", if16.out_valid, 16'hFFFF);
    chk("bc_all_data", if16.out_data, {16{8'h5A}});
    if16.in_valid = 1'b0; if16.in_bcast = 1'b0; if16.out_ready = 16'hFFFF;
    @(posedge clk); #1;
    if16.in_valid = 1'b1; if16.in_sel = 4'd4; if16.in_data = 8'h44; if16.out_ready = 16'h0000;
    @(posedge clk); #1;
    if16.in_bcast = 1'b1; if16.in_data = 8'h5A;
    @(negedge clk);
    chk("bc_stalled_ready", if16.in_ready, 1'b0);
    @(posedge clk); #1;
    chk("bc_stalled_valid", if16.out_valid, 16'h0010);
    chk("bc_stalled_data4", if16.out_data[39:32], 8'h44);
    if10.in_valid = 1'b1; if10.in_bcast = 1'b1; if10.in_sel = 4'd12; if10.in_data = 8'hB1;
    @(posedge clk); #1;
    chk("bc10_valid", if10.out_valid, 10'h3FF);
    chk("bc10_no_drop", if10.drop_cnt, 16'd0);
`endif

    idle_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
